fir_seq: RTL and testbench

FIR_SEQ -- requirements
Module: fir_seq

---
 rtl/fir_seq.sv | 133 +++++++++++++
 tb/tb_fir_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq.sv
// Sequencer that feeds one block of LEN samples plus two zero-flush samples
// into an external 3-tap FIR, and qualifies the FIR result as a stream.
module fir_seq #(
    parameter int LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [3:0] cfg_data,
    input  logic       start,
    input  logic       s_valid,
    input  logic [3:0] s_data,
    output logic       s_ready,
    output logic [3:0] x0,
    output logic [3:0] h0,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic       fir_en,
    output logic       fir_clr,
    input  logic [7:0] y,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state_o
);

    // Upstream handshake: a sample transfers on a rising edge where
    // s_valid & s_ready; s_ready is high only in RUN and does not depend on s_valid.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic            flush_q;
    logic [3:0]      x0_q;
    logic [3:0]      h0_q;
    logic [3:0]      h1_q;
    logic [3:0]      h2_q;
    logic            fir_en_q;
    logic            fir_clr_q;
    logic            m_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            flush_q   <= 1'b0;
            x0_q      <= 4'd0;
            h0_q      <= 4'd0;
            h1_q      <= 4'd0;
            h2_q      <= 4'd0;
            fir_en_q  <= 1'b0;
            fir_clr_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            // The FIR result appears one edge after the update edge it was enabled on.
            m_valid_q <= fir_en_q;
            fir_en_q  <= 1'b0;
            fir_clr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_we) begin
                        case (cfg_addr)
                            2'd0:    h0_q <= cfg_data;
                            2'd1:    h1_q <= cfg_data;
                            2'd2:    h2_q <= cfg_data;
                            default: ;
                        endcase
                    end
                    if (start) begin
                        state_q   <= S_CLR;
                        fir_clr_q <= 1'b1;
                        count_q   <= '0;
                    end
                end
                S_CLR: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (s_valid) begin
                        x0_q     <= s_data;
                        fir_en_q <= 1'b1;
                        count_q  <= count_q + 1'b1;
                        if (count_q == LAST) begin
                            state_q <= S_FLUSH;
                            flush_q <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    // Two zero samples push the last real samples through the taps.
                    x0_q     <= 4'd0;
                    fir_en_q <= 1'b1;
                    flush_q  <= 1'b1;
                    if (flush_q) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = (state_q == S_RUN);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign x0          = x0_q;
    assign h0          = h0_q;
    assign h1          = h1_q;
    assign h2          = h2_q;
    assign fir_en      = fir_en_q;
    assign fir_clr     = fir_clr_q;
    assign m_valid     = m_valid_q;
    assign m_data      = y;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_seq.sv
// Directed bench for fir_seq with a behavioural 3-tap FIR closing the loop.
module tb_fir_seq;

    localparam int LEN = 8;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       start;
    logic       s_valid;
    logic [3:0] s_data;
    logic       s_ready;
    logic [3:0] x0;
    logic [3:0] h0;
    logic [3:0] h1;
    logic [3:0] h2;
    logic       fir_en;
    logic       fir_clr;
    logic [7:0] y;
    logic       m_valid;
    logic [7:0] m_data;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    fir_seq #(.LEN(LEN)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .x0(x0), .h0(h0), .h1(h1), .h2(h2), .fir_en(fir_en),
        .fir_clr(fir_clr), .y(y), .m_valid(m_valid), .m_data(m_data),
        .busy(busy), .done(done), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External FIR: y = h0*x[n] + h1*x[n-1] + h2*x[n-2], registered.
    logic [3:0] d1;
    logic [3:0] d2;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= 4'd0;
            d2 <= 4'd0;
            y  <= 8'd0;
        end else if (fir_clr) begin
            d1 <= 4'd0;
            d2 <= 4'd0;
            y  <= 8'd0;
        end else if (fir_en) begin
            y  <= 8'(8'(h0) * 8'(x0) + 8'(h1) * 8'(d1) + 8'(h2) * 8'(d2));
            d1 <= x0;
            d2 <= d1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) got_q.push_back(m_data);
        if (done) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 0);
        check({tag, "_h0"}, 32'(h0), 0);
        check({tag, "_h1"}, 32'(h1), 0);
        check({tag, "_h2"}, 32'(h2), 0);
        check({tag, "_x0"}, 32'(x0), 0);
        check({tag, "_fir_en"}, 32'(fir_en), 0);
        check({tag, "_fir_clr"}, 32'(fir_clr), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [3:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic run_block(input string tag, input bit gaps, input bit inject);
        int  sent;
        int  cyc;
        int  base;
        bit  acc;
        bit  rdy;
        got_q.delete();
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_fir_clr"}, 32'(fir_clr), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        sent = 0;
        cyc  = 0;
        while (sent < LEN && cyc < 100) begin
            s_valid = gaps ? ((cyc % 2) == 1) : 1'b1;
            s_data  = 4'(sent + 1);
            if (inject && sent == 3) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'd0;
                cfg_data = 4'd7;
                start    = 1'b1;
            end
            #1;
            acc = s_valid && s_ready;
            rdy = s_ready;
            @(negedge clk);
            cfg_we = 1'b0;
            start  = 1'b0;
            if (acc) begin
                check($sformatf("%s_x0_%0d", tag, sent), 32'(x0), sent + 1);
                check($sformatf("%s_fir_en_acc_%0d", tag, sent), 32'(fir_en), 1);
                sent++;
            end else if (rdy) begin
                check($sformatf("%s_fir_en_bubble_%0d", tag, cyc), 32'(fir_en), 0);
            end
            cyc++;
        end
        s_valid = 1'b0;
        check({tag, "_all_sent"}, sent, LEN);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(done), 1);
        @(negedge clk);
        check({tag, "_busy_after_done"}, 32'(busy), 0);
        check({tag, "_done_one_cycle"}, 32'(done), 0);
        repeat (3) @(negedge clk);
        check({tag, "_n_out"}, got_q.size(), LEN + 2);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_out%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_done_cnt"}, done_cnt - base, 1);
    endtask

    initial begin
        int base;
        exp_q = '{8'd1, 8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24, 8'd28, 8'd23, 8'd8};
        reset    = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 4'd0;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 4'd0;
        #3;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        cfg_write(2'd0, 4'd1);
        cfg_write(2'd1, 4'd2);
        cfg_write(2'd2, 4'd1);
        cfg_write(2'd3, 4'hF);
        check("cfg_h0", 32'(h0), 1);
        check("cfg_h1", 32'(h1), 2);
        check("cfg_h2", 32'(h2), 1);
        check("cfg_x0", 32'(x0), 0);
        check("cfg_busy", 32'(busy), 0);
        check("cfg_fir_en", 32'(fir_en), 0);

        run_block("blk", 1'b0, 1'b0);
        run_block("blk2", 1'b0, 1'b0);
        run_block("bub", 1'b1, 1'b0);
        run_block("inj", 1'b0, 1'b1);
        check("inj_h0", 32'(h0), 1);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 4'd1;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            s_data = 4'(k);
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("mid_state_run", 32'(dbg_state), 2);
        check("mid_x0", 32'(x0), 3);
        base = done_cnt;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt - base, 0);
        check("rst_idle", 32'(busy), 0);

        cfg_write(2'd0, 4'd1);
        cfg_write(2'd1, 4'd2);
        cfg_write(2'd2, 4'd1);
        run_block("post_rst", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
